mem_port_arbiter: RTL and testbench

- Shares one valid/ready memory port between the core's instruction-fetch and data requesters. Targets a single-port RAM or external bus.
- Sits between riscv_core's imem_*/dmem_* interfaces and one memory port.
- Registers each granted request and forwards the response to the granted requester.
- Data has priority, with a starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / data) sharing one valid/ready memory port.
// Data wins by default; a saturating starve counter forces a fetch grant when it hits STARVE_LIMIT.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    imem_valid_i,
    output logic                    imem_ready_o,
    input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
    input  logic [DATA_WIDTH-1:0]   imem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] imem_we_i,
    output logic [DATA_WIDTH-1:0]   imem_rdata_o,
    input  logic                    dmem_valid_i,
    output logic                    dmem_ready_o,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_we_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic [1:0]              state_dbg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Handshake on every port: valid plus fields are held until ready; ready is a
    // single-cycle pulse and rdata is only meaningful in that cycle. The requester
    // may drop valid or present a new request in the cycle after ready.

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       go_i;
    logic       go_d;
    logic       done;

    assign done         = ((state == GNT_I) || (state == GNT_D)) && mem_ready_i;
    assign imem_ready_o = (state == GNT_I) && mem_ready_i;
    assign dmem_ready_o = (state == GNT_D) && mem_ready_i;
    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;
    assign state_dbg    = state;

    // On a completion edge only the other requester may be granted; the finishing one's valid is stale.
    always_comb begin
        go_i = 1'b0;
        go_d = 1'b0;
        case (state)
            IDLE: begin
                if (dmem_valid_i && !(imem_valid_i && (starve_cnt == LIMIT))) begin
                    go_d = 1'b1;
                end else if (imem_valid_i) begin
                    go_i = 1'b1;
                end
            end
            GNT_I:   go_d = mem_ready_i && dmem_valid_i;
            GNT_D:   go_i = mem_ready_i && imem_valid_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= '0;
            starve_cnt  <= '0;
        end else if (go_d) begin
            state       <= GNT_D;
            mem_valid_o <= 1'b1;
            mem_addr_o  <= dmem_addr_i;
            mem_wdata_o <= dmem_wdata_i;
            mem_we_o    <= dmem_we_i;
            if (!imem_valid_i) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else if (go_i) begin
            state       <= GNT_I;
            mem_valid_o <= 1'b1;
            mem_addr_o  <= imem_addr_i;
            mem_wdata_o <= imem_wdata_i;
            mem_we_o    <= imem_we_i;
            starve_cnt  <= '0;
        end else if (done || (state == 2'd3)) begin
            state       <= IDLE;
            mem_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, simultaneous requests,
// starvation guard, field stability under stall, mid-transaction reset, idle ready.
module tb_mem_port_arbiter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_I = 2'd1;
    localparam logic [1:0] S_GNT_D = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        imem_valid;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [3:0]  imem_we;
    logic [31:0] imem_rdata;
    logic        dmem_valid;
    logic        dmem_ready;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_valid_i (imem_valid),
        .imem_ready_o (imem_ready),
        .imem_addr_i  (imem_addr),
        .imem_wdata_i (imem_wdata),
        .imem_we_i    (imem_we),
        .imem_rdata_o (imem_rdata),
        .dmem_valid_i (dmem_valid),
        .dmem_ready_o (dmem_ready),
        .dmem_addr_i  (dmem_addr),
        .dmem_wdata_i (dmem_wdata),
        .dmem_we_i    (dmem_we),
        .dmem_rdata_o (dmem_rdata),
        .mem_valid_o  (mem_valid),
        .mem_ready_i  (mem_ready),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we),
        .mem_rdata_i  (mem_rdata),
        .state_dbg    (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        imem_valid = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        imem_we    = '0;
        dmem_valid = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_we    = '0;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h0BAD_0BAD;
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_imem_ready", 32'(imem_ready), 32'd0);
        check("rst_dmem_ready", 32'(dmem_ready), 32'd0);
        tick();
        check("rst_hold_mem_valid", 32'(mem_valid), 32'd0);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        tick();

        // Spurious memory ready while idle
        mem_ready = 1'b1;
        #1;
        check("idle_spur_imem_ready", 32'(imem_ready), 32'd0);
        check("idle_spur_dmem_ready", 32'(dmem_ready), 32'd0);
        tick();
        check("idle_spur_state", 32'(dbg_state), 32'(S_IDLE));
        check("idle_spur_mem_valid", 32'(mem_valid), 32'd0);
        mem_ready = 1'b0;

        // Single fetch, memory answers in the second grant cycle
        imem_valid = 1'b1;
        imem_addr  = 32'h100;
        #1;
        check("fetch_valid_not_yet", 32'(mem_valid), 32'd0);
        tick();
        check("fetch_mem_valid", 32'(mem_valid), 32'd1);
        check("fetch_mem_addr", mem_addr, 32'h100);
        check("fetch_state", 32'(dbg_state), 32'(S_GNT_I));
        check("fetch_stall_ready", 32'(imem_ready), 32'd0);
        tick();
        check("fetch_stall2_ready", 32'(imem_ready), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("fetch_imem_ready", 32'(imem_ready), 32'd1);
        check("fetch_imem_rdata", imem_rdata, 32'hDEAD_BEEF);
        check("fetch_dmem_ready", 32'(dmem_ready), 32'd0);
        tick();
        imem_valid = 1'b0;
        mem_ready  = 1'b0;
        #1;
        check("fetch_done_state", 32'(dbg_state), 32'(S_IDLE));
        check("fetch_done_mem_valid", 32'(mem_valid), 32'd0);
        check("fetch_done_ready", 32'(imem_ready), 32'd0);

        // Simultaneous requests, zero-wait memory: data first, then fetch with no idle gap
        imem_valid = 1'b1;
        imem_addr  = 32'h200;
        dmem_valid = 1'b1;
        dmem_addr  = 32'h400;
        dmem_we    = 4'hF;
        dmem_wdata = 32'h1234_5678;
        mem_ready  = 1'b1;
        #1;
        check("both_idle_dmem_ready", 32'(dmem_ready), 32'd0);
        tick();
        mem_rdata = 32'h1111_2222;
        #1;
        check("both_d_state", 32'(dbg_state), 32'(S_GNT_D));
        check("both_d_addr", mem_addr, 32'h400);
        check("both_d_we", 32'(mem_we), 32'hF);
        check("both_d_wdata", mem_wdata, 32'h1234_5678);
        check("both_d_dmem_ready", 32'(dmem_ready), 32'd1);
        check("both_d_imem_ready", 32'(imem_ready), 32'd0);
        check("both_d_rdata", dmem_rdata, 32'h1111_2222);
        tick();
        dmem_valid = 1'b0;
        mem_rdata  = 32'h3333_4444;
        #1;
        check("both_i_state", 32'(dbg_state), 32'(S_GNT_I));
        check("both_i_mem_valid", 32'(mem_valid), 32'd1);
        check("both_i_addr", mem_addr, 32'h200);
        check("both_i_we", 32'(mem_we), 32'h0);
        check("both_i_imem_ready", 32'(imem_ready), 32'd1);
        check("both_i_dmem_ready", 32'(dmem_ready), 32'd0);
        check("both_i_rdata", imem_rdata, 32'h3333_4444);
        tick();
        imem_valid = 1'b0;
        mem_ready  = 1'b0;
        #1;
        check("both_end_state", 32'(dbg_state), 32'(S_IDLE));
        check("both_end_mem_valid", 32'(mem_valid), 32'd0);

        // Starvation: four data grants while fetch is pending push the counter to the limit
        mem_ready = 1'b1;
        dmem_we   = 4'h0;
        for (int k = 0; k < 4; k++) begin
            imem_valid = 1'b1;
            imem_addr  = 32'h300;
            dmem_valid = 1'b1;
            dmem_addr  = 32'h500 + 32'(k * 4);
            #1;
            check("starve_idle_state", 32'(dbg_state), 32'(S_IDLE));
            tick();
            imem_valid = 1'b0;
            #1;
            check("starve_d_state", 32'(dbg_state), 32'(S_GNT_D));
            check("starve_d_addr", mem_addr, 32'h500 + 32'(k * 4));
            check("starve_d_ready", 32'(dmem_ready), 32'd1);
            tick();
        end
        imem_valid = 1'b1;
        imem_addr  = 32'h300;
        dmem_valid = 1'b1;
        dmem_addr  = 32'h600;
        #1;
        check("starve_pre_state", 32'(dbg_state), 32'(S_IDLE));
        tick();
        check("starve_i_state", 32'(dbg_state), 32'(S_GNT_I));
        check("starve_i_addr", mem_addr, 32'h300);
        check("starve_i_imem_ready", 32'(imem_ready), 32'd1);
        check("starve_i_dmem_ready", 32'(dmem_ready), 32'd0);
        tick();
        imem_valid = 1'b0;
        #1;
        check("starve_resume_state", 32'(dbg_state), 32'(S_GNT_D));
        check("starve_resume_addr", mem_addr, 32'h600);
        check("starve_resume_ready", 32'(dmem_ready), 32'd1);
        tick();
        dmem_valid = 1'b0;
        mem_ready  = 1'b0;
        #1;
        check("starve_end_state", 32'(dbg_state), 32'(S_IDLE));

        // Requester changes fields while the memory stalls: registered fields must not move
        dmem_valid = 1'b1;
        dmem_addr  = 32'h40;
        dmem_wdata = 32'hCAFE_0000;
        dmem_we    = 4'h3;
        tick();
        dmem_addr  = 32'h80;
        dmem_wdata = 32'hFFFF_FFFF;
        dmem_we    = 4'hC;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_addr", mem_addr, 32'h40);
            check("stall_wdata", mem_wdata, 32'hCAFE_0000);
            check("stall_we", 32'(mem_we), 32'h3);
            check("stall_ready", 32'(dmem_ready), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("stall_done_ready", 32'(dmem_ready), 32'd1);
        check("stall_done_addr", mem_addr, 32'h40);
        tick();
        dmem_valid = 1'b0;
        mem_ready  = 1'b0;
        #1;
        check("stall_end_mem_valid", 32'(mem_valid), 32'd0);

        // Reset in the middle of a stalled fetch
        imem_valid = 1'b1;
        imem_addr  = 32'h700;
        tick();
        check("mid_rst_pre_valid", 32'(mem_valid), 32'd1);
        check("mid_rst_pre_state", 32'(dbg_state), 32'(S_GNT_I));
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        mem_ready  = 1'b1;
        #1;
        check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_imem_ready", 32'(imem_ready), 32'd0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_state", 32'(dbg_state), 32'(S_IDLE));
            check("post_rst_imem_ready", 32'(imem_ready), 32'd0);
            check("post_rst_dmem_ready", 32'(dmem_ready), 32'd0);
        end
        mem_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
